// File: rtl/lsu_dmem_if.sv
// Load/store unit between the MEM stage and the data-memory port.
// Aligns MEM-stage accesses onto 4 byte lanes. Drives the proc_req/mem_rdy/valid
// handshake and stalls the pipeline while an access is outstanding.
// Returns formatted load data.
//
// state | meaning
// IDLE  | no access outstanding; alignment checked, aligned request latched
// REQ   | proc_req high, waiting for mem_rdy
// WAIT  | load accepted, waiting for valid read data
// DONE  | one-cycle completion; pipeline advances, ld_valid/bus_err pulse
//
// nbits is fixed at 32: the lane logic assumes exactly four byte lanes.
module lsu_dmem_if #(
   parameter int nbits   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [nbits-1:0] req_addr,
   input  logic [nbits-1:0] req_wdata,
   output logic             stall,
   output logic [nbits-1:0] ld_data,
   output logic             ld_valid,
   output logic             misalign,
   output logic             bus_err,
   output logic             proc_req,
   output logic             we,
   output logic [nbits-1:0] addr,
   output logic [nbits-1:0] wdata,
   output logic [3:0]       be,
   input  logic             mem_rdy,
   input  logic             valid,
   input  logic [nbits-1:0] rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t             state_q, state_d;
   logic               we_q;
   logic [1:0]         size_q;
   logic               uns_q;
   logic [1:0]         lane_q;
   logic [nbits-1:0]   addr_q;
   logic [nbits-1:0]   wdata_q;
   logic [3:0]         be_q;
   logic [nbits-1:0]   ld_data_q;
   logic               err_q;
   logic [7:0]         cnt_q;

   logic               aligned;
   logic               start;
   logic               expire;
   logic [7:0]         cnt_inc;
   logic [3:0]         be_new;
   logic [nbits-1:0]   wdata_new;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [nbits-1:0]   ld_fmt;

   // Alignment check and lane mapping of the incoming MEM-stage request
   always_comb begin
      aligned   = 1'b0;
      be_new    = 4'b0000;
      wdata_new = req_wdata;
      case (req_size)
         2'b00: begin
            aligned   = 1'b1;
            be_new    = 4'b0001 << req_addr[1:0];
            wdata_new = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            aligned   = ~req_addr[0];
            be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            aligned   = (req_addr[1:0] == 2'b00);
            be_new    = 4'b1111;
            wdata_new = req_wdata;
         end
         default: begin
            aligned   = 1'b0;
            be_new    = 4'b0000;
            wdata_new = req_wdata;
         end
      endcase
   end

   // Load data lane extraction and sign/zero extension
   always_comb begin
      byte_sel = rdata[{lane_q, 3'b000} +: 8];
      half_sel = lane_q[1] ? rdata[31:16] : rdata[15:0];
      case (size_q)
         2'b00:   ld_fmt = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   ld_fmt = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_fmt = rdata;
      endcase
   end

   assign start   = (state_q == S_IDLE) && req_valid && aligned;
   assign cnt_inc = cnt_q + 8'd1;
   // Expiry fires in the cycle that would complete the TIMEOUT-th REQ/WAIT cycle
   assign expire  = (TIMEOUT != 0) && (cnt_inc == TMO);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; handshake inputs take priority over expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_REQ;
         S_REQ: begin
            if (mem_rdy)     state_d = we_q ? S_DONE : S_WAIT;
            else if (expire) state_d = S_DONE;
         end
         S_WAIT: begin
            if (valid)       state_d = S_DONE;
            else if (expire) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Request latch, timeout counter and load-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         uns_q     <= 1'b0;
         lane_q    <= 2'b00;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= 4'b0000;
         ld_data_q <= '0;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  lane_q  <= req_addr[1:0];
                  addr_q  <= {req_addr[nbits-1:2], 2'b00};
                  wdata_q <= wdata_new;
                  be_q    <= be_new;
                  err_q   <= 1'b0;
                  cnt_q   <= 8'd0;
               end
            end
            S_REQ: begin
               cnt_q <= cnt_inc;
               if (!mem_rdy && expire) begin
                  err_q     <= 1'b1;
                  ld_data_q <= '0;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_inc;
               if (valid) begin
                  ld_data_q <= ld_fmt;
               end else if (expire) begin
                  err_q     <= 1'b1;
                  ld_data_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode from state and latched request
   always_comb begin
      proc_req = (state_q == S_REQ);
      stall    = start || (state_q == S_REQ) || (state_q == S_WAIT);
      ld_valid = (state_q == S_DONE) && !we_q && !err_q;
      bus_err  = (state_q == S_DONE) && err_q;
      misalign = (state_q == S_IDLE) && req_valid && !aligned;
      we       = we_q;
      addr     = addr_q;
      wdata    = wdata_q;
      be       = be_q;
      ld_data  = ld_data_q;
   end

endmodule

// File: doc/lsu_dmem_if.md
Name: lsu_dmem_if

Overview:
- Load/store unit between the MEM pipeline stage and the data-memory port.
- Converts a MEM-stage access (size, sign, address, store data) into a word-aligned request with byte enables, and runs the proc_req/mem_rdy/valid handshake.
- Freezes the pipeline through stall while an access is outstanding.
- Returns load data lane-extracted and sign- or zero-extended for write-back.

Parameters:
- nbits, 32, datapath/address width; only 32 is supported because the byte-lane logic is fixed at 4 lanes.
- TIMEOUT, 255, max cycles in REQ+WAIT before abort; 0 disables; 8-bit counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  MEM stage holds a load/store this cycle
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  1=zero-extend load (LBU/LHU)
- req_addr  in  nbits  byte address (ALU result)
- req_wdata  in  nbits  store data (rs2)
- stall  out  1  freeze pipeline (to CU)
- ld_data  out  nbits  formatted load data
- ld_valid  out  1  one-cycle pulse, ld_data valid
- misalign  out  1  one-cycle misaligned/illegal flag
- bus_err  out  1  one-cycle timeout flag
- proc_req  out  1  request to data memory
- we  out  1  write enable to memory
- addr  out  nbits  word-aligned address {req_addr[31:2],2'b00}
- wdata  out  nbits  lane-replicated store data
- be  out  4  byte enables
- mem_rdy  in  1  memory accepts request
- valid  in  1  read data valid
- rdata  in  nbits  read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; all of stall, proc_req, we, addr, wdata, be, ld_data, ld_valid, misalign, bus_err and the counter are 0. A reset mid-transaction aborts it; proc_req is 0 from the next edge.
- Alignment check, evaluated in IDLE:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]!=0 is misaligned;
  - size 11 is illegal.
  - Misaligned/illegal requests get no memory access: misalign=1 combinationally that cycle, stall=0, ld_valid=0, and the state stays IDLE.
- IDLE:
  - req_valid && aligned -> latch we/size/unsigned/addr/wdata/be/lane; stall=1 combinationally; next state REQ.
- REQ:
  - proc_req=1 with addr/we/wdata/be stable.
  - On mem_rdy=1: a store goes to DONE; a load goes to WAIT.
  - valid is ignored in REQ.
- WAIT:
  - On valid=1: capture formatted rdata into ld_data; next state DONE.
  - proc_req=0 in WAIT.
- DONE:
  - Exactly one cycle; stall=0; ld_valid=1 for loads only; next state IDLE.
  - req_valid is ignored in DONE because the same instruction is still present. The pipeline advances at this edge.
- Stall: stall = (IDLE && req_valid && aligned) || REQ || WAIT.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it equals TIMEOUT (TIMEOUT!=0): drop proc_req, go to DONE, ld_data=0, ld_valid=0, bus_err=1 for that DONE cycle.
  - mem_rdy or valid arriving in the same cycle as expiry takes priority over the timeout.
- Byte enables and store data:
  - byte: be=1<<addr[1:0]; wdata = store byte replicated ×4.
  - half: be=0011 (addr[1]=0) or 1100; wdata = store half replicated ×2.
  - word: be=1111; wdata = req_wdata.
  - be is driven identically for loads.
- Load format: byte lane addr[1:0]; half lane addr[1]; sign-extend unless unsigned. Word loads ignore the unsigned flag.
- Latency:
  - Load with mem_rdy in the first REQ cycle and valid on the next cycle: 4 cycles from req_valid to DONE (IDLE, REQ, WAIT, DONE); stall high for 3 cycles.
  - Store: 3 cycles (IDLE, REQ, DONE).

Test Plan:
- LB addr=0x103, rdata=0x80FF1234, mem_rdy=1 immediately, valid next cycle -> be=1000, addr=0x100, ld_data=0xFFFFFF80, ld_valid pulse in cycle 3, stall high cycles 0-2.
- LHU addr=0x202, rdata=0xBEEF0000 -> ld_data=0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
- SB addr=0x41, req_wdata=0x123456AB, mem_rdy held low 3 cycles -> proc_req stays high with stable wdata=0xABABABAB and be=0010 until mem_rdy; stall drops in DONE; no ld_valid.
- SW addr=0x42 -> misalign=1 for one cycle, proc_req never asserts, stall=0. Also size=11 at any address -> misalign=1.
- TIMEOUT=4, load with mem_rdy=1 and valid never asserted -> bus_err pulse after the 4th REQ/WAIT cycle, ld_data=0, FSM returns to IDLE.
- rst asserted during WAIT -> next cycle proc_req=0, stall=0, state=IDLE; a following load completes normally.
